// File: rtl/bfm_apbslave_pkg.sv
// Shared types and helpers for the APB3 slave memory model.
package bfm_apbslave_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int WAIT_W = 4;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Byte-address bits above the memory window; any set bit is an out-of-range access.
  function automatic logic [ADDR_W-1:0] err_addr_mask(input int depth_log2);
    return ~((32'd1 << (depth_log2 + 2)) - 32'd1);
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bfm_apbslave_ram.sv
// Single-port word memory with registered read. The array is left unreset so
// benches may preload it hierarchically and data survives a bus reset.
module bfm_apbslave_ram
  import bfm_apbslave_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_rdata;

  // Write port and registered read port share one address.
  always_ff @(posedge clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bfm_apbslave_mem.sv
// APB3 slave memory model: setup/access FSM, wait-state counter, address and
// alignment error responses, sticky protocol checker, saturating transfer counters.
module bfm_apbslave_mem
  import bfm_apbslave_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int SEL_INDEX   = 0,
  parameter int CHECK_ALIGN = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [15:0]       PSEL,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [WAIT_W-1:0] WAITS,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              PROTERR,
  output logic [CNT_W-1:0]  WRCOUNT,
  output logic [CNT_W-1:0]  RDCOUNT
);

  localparam logic [ADDR_W-1:0] ERR_MASK = err_addr_mask(DEPTH_LOG2);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic                r_err;
  logic                r_rd_ok;
  logic                r_pready;
  logic [WAIT_W-1:0]   r_cnt;
  logic                r_proterr;
  logic [CNT_W-1:0]    r_wrcnt;
  logic [CNT_W-1:0]    r_rdcnt;

  logic                  w_sel;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_idle_viol;
  logic                  w_drop;
  logic                  w_mismatch;
  logic                  w_complete;
  logic                  w_we;
  logic                  w_re;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic [DATA_W-1:0]     w_ram_q;
  logic                  w_unused;

  assign w_sel    = PSEL[SEL_INDEX];
  assign w_unused = ^PSEL;

  assign w_err = ((PADDR & ERR_MASK) != '0) ||
                 ((CHECK_ALIGN != 0) && (PADDR[1:0] != 2'b00));

  assign w_setup     = (r_state == IDLE) && w_sel && !PENABLE;
  assign w_idle_viol = (r_state == IDLE) && w_sel && PENABLE;
  // Master abandoned the access phase before completion.
  assign w_drop      = (r_state == ACCESS) && !(w_sel && PENABLE);
  assign w_mismatch  = (r_state == ACCESS) && w_sel && PENABLE &&
                       ((PADDR != r_addr) || (PWRITE != r_write) ||
                        (r_write && (PWDATA != r_wdata)));
  assign w_complete  = (r_state == ACCESS) && w_sel && PENABLE && r_pready;

  // Reset on the completion edge must still block the commit.
  assign w_we = w_complete && r_write && !r_err && !PRESET;
  // Read in the setup cycle so data is ready for a zero-wait access phase.
  assign w_re = w_setup && !PWRITE && !w_err && !PRESET;

  assign w_ram_addr = (r_state == ACCESS) ? r_addr[DEPTH_LOG2+1:2] : PADDR[DEPTH_LOG2+1:2];

  bfm_apbslave_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (PCLK),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  // Transfer FSM: capture in setup, count wait states, finish or abandon in access.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_rd_ok  <= 1'b0;
      r_pready <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_addr   <= PADDR;
            r_wdata  <= PWDATA;
            r_write  <= PWRITE;
            r_err    <= w_err;
            r_rd_ok  <= !PWRITE && !w_err;
            r_cnt    <= WAITS;
            r_pready <= (WAITS == '0);
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_drop || r_pready) begin
            r_pready <= 1'b0;
            r_err    <= 1'b0;
            r_rd_ok  <= 1'b0;
            r_state  <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == WAIT_W'(1)) r_pready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge PCLK) begin
    if (PRESET)
      r_proterr <= 1'b0;
    else if (w_idle_viol || w_drop || w_mismatch)
      r_proterr <= 1'b1;
  end

  // Good-transfer counters; errored transfers are not counted.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wrcnt <= '0;
      r_rdcnt <= '0;
    end else if (w_complete && !r_err) begin
      if (r_write) r_wrcnt <= sat_inc(r_wrcnt);
      else         r_rdcnt <= sat_inc(r_rdcnt);
    end
  end

  assign PREADY  = (r_state == ACCESS) && r_pready;
  assign PSLVERR = (r_state == ACCESS) && r_pready && r_err;
  assign PRDATA  = ((r_state == ACCESS) && r_pready && r_rd_ok) ? w_ram_q : '0;
  assign PROTERR = r_proterr;
  assign WRCOUNT = r_wrcnt;
  assign RDCOUNT = r_rdcnt;

endmodule

// File: tb/tb_bfm_apbslave_mem.sv
// Randomized self-checking bench for bfm_apbslave_mem against a word-array model.
module tb_bfm_apbslave_mem;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [15:0] PSEL;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  WAITS;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        PROTERR;
  logic [15:0] WRCOUNT;
  logic [15:0] RDCOUNT;

  int checks = 0;
  int errors = 0;

  // Reference model: 256 words, counters, sticky flag.
  logic [31:0] m_mem [0:255];
  logic [15:0] m_wr;
  logic [15:0] m_rd;
  logic        m_prot;

  always #5 PCLK = ~PCLK;

  bfm_apbslave_mem #(
    .DEPTH_LOG2 (8),
    .SEL_INDEX  (0),
    .CHECK_ALIGN(1)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PSEL   (PSEL),
    .PADDR  (PADDR),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .WAITS  (WAITS),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .PROTERR(PROTERR),
    .WRCOUNT(WRCOUNT),
    .RDCOUNT(RDCOUNT)
  );

  function automatic logic m_err(input logic [31:0] a);
    return (a > 32'h0000_03FF) || (a % 4 != 0);
  endfunction

  function automatic logic [15:0] m_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic bus_idle;
    @(posedge PCLK); #1;
    PSEL = '0; PENABLE = 1'b0;
  endtask

  task automatic check_counts(input string nm);
    @(negedge PCLK);
    checks++;
    if (WRCOUNT !== m_wr || RDCOUNT !== m_rd || PROTERR !== m_prot) begin
      errors++;
      $display("FAIL %s counts got wr=%0d rd=%0d prot=%b want wr=%0d rd=%0d prot=%b",
               nm, WRCOUNT, RDCOUNT, PROTERR, m_wr, m_rd, m_prot);
    end
  endtask

  // One full transfer; leaves PSEL/PENABLE high so a following call is back-to-back.
  task automatic xfer(input string nm, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input int waits, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        got;
    int          lat;
    exp_err = m_err(a);
    exp_rd  = (w || exp_err) ? 32'h0 : m_mem[a[9:2]];
    @(posedge PCLK); #1;
    PSEL = 16'h0001; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d; WAITS = waits[3:0];
    @(negedge PCLK);
    checks++;
    if (PREADY !== 1'b0) begin
      errors++; $display("FAIL %s setup_pready got %b want 0", nm, PREADY);
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    WAITS   = 4'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge PCLK);
      lat++;
      if (PREADY === 1'b1) got = 1'b1;
      else begin
        checks++;
        if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
          errors++; $display("FAIL %s wait_outputs got rd=%h err=%b want 0 0", nm, PRDATA, PSLVERR);
        end
      end
    end
    rd = PRDATA;
    checks++;
    if (!got || lat != waits + 1) begin
      errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, waits + 1);
    end
    checks++;
    if (PSLVERR !== exp_err) begin
      errors++; $display("FAIL %s pslverr got %b want %b", nm, PSLVERR, exp_err);
    end
    checks++;
    if (PRDATA !== exp_rd) begin
      errors++; $display("FAIL %s prdata got %h want %h", nm, PRDATA, exp_rd);
    end
    if (!exp_err) begin
      if (w) begin m_mem[a[9:2]] = d; m_wr = m_inc(m_wr); end
      else   m_rd = m_inc(m_rd);
    end
  endtask

  task automatic do_reset(input string nm);
    @(posedge PCLK); #1;
    PRESET = 1'b1; PSEL = '0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    m_wr = '0; m_rd = '0; m_prot = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PRDATA, PREADY, PSLVERR, PROTERR, WRCOUNT, RDCOUNT} !== '0) begin
      errors++;
      $display("FAIL %s outputs got rd=%h rdy=%b err=%b prot=%b wr=%0d rdc=%0d want all 0",
               nm, PRDATA, PREADY, PSLVERR, PROTERR, WRCOUNT, RDCOUNT);
    end
  endtask

  task automatic test_reset;
    do_reset("reset");
  endtask

  task automatic test_basic;
    logic [31:0] rd;
    xfer("basic_wr", 32'h10, 1'b1, 32'hDEADBEEF, 0, rd);
    xfer("basic_rd", 32'h10, 1'b0, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_data got %h want deadbeef", rd);
    end
    bus_idle();
    check_counts("basic");
  endtask

  task automatic test_fill;
    logic [31:0] rd;
    for (int i = 0; i < 256; i++)
      xfer("fill", 32'(i * 4), 1'b1, $urandom, int'($urandom_range(0, 1)), rd);
    bus_idle();
    check_counts("fill");
  endtask

  task automatic test_waits;
    logic [31:0] rd;
    xfer("waits_wr", 32'h20, 1'b1, 32'h12345678, 1, rd);
    xfer("waits_rd", 32'h20, 1'b0, 32'h0, 3, rd);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++; $display("FAIL waits_data got %h want 12345678", rd);
    end
    bus_idle();
    check_counts("waits");
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    xfer("err_wr_range", 32'h400, 1'b1, 32'hCAFE0001, 0, rd);
    xfer("err_wr_align", 32'h02, 1'b1, 32'hCAFE0002, 1, rd);
    bus_idle();
    check_counts("err_wr");
    xfer("err_rd_range", 32'h400, 1'b0, 32'h0, 0, rd);
    xfer("err_rd_high", 32'h8000_0010, 1'b0, 32'h0, 2, rd);
    xfer("err_mem0", 32'h00, 1'b0, 32'h0, 0, rd);
    bus_idle();
    check_counts("err_rd");
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] rd;
    int          r;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 255)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = a | (32'($urandom_range(1, 255)) << 10);
      xfer("random", a, 1'($urandom), $urandom, int'($urandom_range(0, 3)), rd);
    end
    bus_idle();
    check_counts("random");
  endtask

  task automatic test_addr_change;
    logic [31:0] rd;
    int          lat;
    @(posedge PCLK); #1;
    PSEL = 16'h0001; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b0; WAITS = 4'd2;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = 32'h14;
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
    end while (PREADY !== 1'b1 && lat < 20);
    checks++;
    if (lat != 3 || PRDATA !== m_mem[4] || PSLVERR !== 1'b0) begin
      errors++;
      $display("FAIL addr_change xfer got lat=%0d rd=%h err=%b want lat=3 rd=%h err=0",
               lat, PRDATA, PSLVERR, m_mem[4]);
    end
    m_rd = m_inc(m_rd);
    m_prot = 1'b1;
    bus_idle();
    check_counts("addr_change");
    xfer("after_change", 32'h14, 1'b0, 32'h0, 0, rd);
    bus_idle();
    check_counts("proterr_sticky");
  endtask

  task automatic test_drop;
    logic [31:0] rd;
    logic [31:0] old;
    do_reset("drop_reset");
    old = m_mem[2];
    @(posedge PCLK); #1;
    PSEL = 16'h0001; PENABLE = 1'b0; PADDR = 32'h08; PWRITE = 1'b1;
    PWDATA = 32'hAAAA5555; WAITS = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = '0; PENABLE = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if (PROTERR !== 1'b1 || PREADY !== 1'b0) begin
      errors++; $display("FAIL drop_flag got prot=%b rdy=%b want 1 0", PROTERR, PREADY);
    end
    m_prot = 1'b1;
    xfer("drop_readback", 32'h08, 1'b0, 32'h0, 0, rd);
    checks++;
    if (rd !== old) begin
      errors++; $display("FAIL drop_mem got %h want %h", rd, old);
    end
    bus_idle();
    check_counts("drop");
  endtask

  task automatic test_reset_access;
    logic [31:0] rd;
    xfer("rst_pre_wr", 32'h10, 1'b1, 32'hDEADBEEF, 0, rd);
    bus_idle();
    // Zero-wait write whose completion edge coincides with reset.
    @(posedge PCLK); #1;
    PSEL = 16'h0001; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b1;
    PWDATA = 32'h0BADF00D; WAITS = 4'd0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = '0; PENABLE = 1'b0;
    m_wr = '0; m_rd = '0; m_prot = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PRDATA, PREADY, PSLVERR, PROTERR, WRCOUNT, RDCOUNT} !== '0) begin
      errors++;
      $display("FAIL rst_access outputs got rd=%h rdy=%b err=%b prot=%b wr=%0d rdc=%0d want all 0",
               PRDATA, PREADY, PSLVERR, PROTERR, WRCOUNT, RDCOUNT);
    end
    xfer("rst_readback", 32'h10, 1'b0, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rst_mem got %h want deadbeef", rd);
    end
    bus_idle();
    check_counts("rst_access");
  endtask

  initial begin
    PRESET = 1'b1; PSEL = '0; PADDR = '0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = '0; WAITS = '0;
    m_wr = '0; m_rd = '0; m_prot = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_fill();
    test_waits();
    test_errors();
    test_random();
    test_addr_change();
    test_drop();
    test_reset_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfm_apbslave_mem.md
Name: bfm_apbslave_mem

Overview:
- APB3 slave memory model for simulation benches. It sits directly downstream of the APB master BFM and consumes its PSEL/PADDR/PENABLE/PWRITE/PWDATA bus.
- Returns PRDATA, PREADY and PSLVERR to the BFM.
- Supports programmable wait states, address-range and alignment error responses, and sticky protocol-violation detection.
- Provides read and write transfer counters for scoreboarding.

Parameters:
- DEPTH_LOG2, 8: memory holds 2**DEPTH_LOG2 32-bit words; byte address range is 0 .. 4*2**DEPTH_LOG2-1.
- SEL_INDEX, 0: which PSEL bit (0..15) selects this slave.
- CHECK_ALIGN, 1: when 1, a PADDR[1:0] value other than 0 gives an error response.

Ports:
- PCLK  in  1  Single clock; all logic on the rising edge.
- PRESET  in  1  Synchronous, active-high reset.
- PSEL  in  16  Slave selects; only PSEL[SEL_INDEX] is used.
- PADDR  in  32  Byte address.
- PENABLE  in  1  APB access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  Write data.
- WAITS  in  4  Wait states to insert; sampled in the setup cycle.
- PRDATA  out  32  Read data; valid only when PREADY=1.
- PREADY  out  1  Transfer-complete strobe.
- PSLVERR  out  1  Error response; valid only when PREADY=1.
- PROTERR  out  1  Sticky protocol-violation flag.
- WRCOUNT  out  16  Completed good writes; saturating counter.
- RDCOUNT  out  16  Completed good reads; saturating counter.

Behaviour:
- Reset (PRESET sampled high at a PCLK edge):
  - State goes to IDLE.
  - PRDATA=0, PREADY=0, PSLVERR=0, PROTERR=0, WRCOUNT=0, RDCOUNT=0.
  - Memory contents are not cleared.
  - Reset during ACCESS abandons the transfer; no write is committed.
- Definitions: sel = PSEL[SEL_INDEX]. err = (PADDR[31:DEPTH_LOG2+2] != 0) OR (CHECK_ALIGN AND PADDR[1:0] != 0).
- State IDLE:
  - sel=1 and PENABLE=0 (setup cycle): capture PADDR, PWRITE and PWDATA; load cnt=WAITS; go to ACCESS.
  - In the same edge, register pready_n=(WAITS==0) and pslverr_n=err.
  - For a read, register prdata_n = err ? 0 : mem[PADDR[DEPTH_LOG2+1:2]].
  - sel=1 and PENABLE=1 while in IDLE: set PROTERR and stay in IDLE.
- State ACCESS:
  - PREADY=pready_n. PSLVERR=pslverr_n AND pready_n. PRDATA=prdata_n while PREADY=1, otherwise 0.
  - cnt>0: decrement cnt; pready_n goes high on the edge where cnt reaches 0. Net result: PREADY rises exactly WAITS cycles after the first access cycle.
  - Completion (sel, PENABLE and PREADY all 1):
    - Write with no error: mem[idx] <= captured PWDATA; WRCOUNT+1.
    - Read with no error: RDCOUNT+1.
    - Errored transfers change neither memory nor counters.
    - Clear pready_n and pslverr_n; return to IDLE.
  - Latency: with WAITS=0, setup at cycle T, PREADY=1 at T+1. Back-to-back transfers need a fresh setup cycle at T+2.
- Protocol checks (each sets PROTERR):
  - In ACCESS, PADDR, PWRITE or (for a write) PWDATA differs from the captured value.
  - sel or PENABLE drops before PREADY. In this case go to IDLE, commit no write, and clear PREADY.
- Counters saturate at 16'hFFFF; they do not wrap.
- PREADY is 0 at all times outside ACCESS.

Decomposition:
- Package bfm_apbslave_pkg: state enum {IDLE, ACCESS}, WAIT_W=4, CNT_W=16, localparam for the error-address mask.
- One sub-module, bfm_apbslave_ram: a synchronous single-port 2**DEPTH_LOG2 x 32 array with a registered read, so the setup-cycle read lands in prdata_n. Its memory array is bench-accessible for preload.
- Top level: FSM, wait counter, checks, counters.

Test Plan:
- WAITS=0: write 0xDEADBEEF to 0x10, then read 0x10. PREADY at T+1 for each transfer; PRDATA=0xDEADBEEF; PSLVERR=0; WRCOUNT=1, RDCOUNT=1.
- WAITS=3: read 0x20 preloaded with 0x12345678. PREADY low for 3 access cycles and high on the 4th with PRDATA=0x12345678.
- DEPTH_LOG2=8: write to 0x400, then write to 0x02. Both complete with PSLVERR=1; memory unchanged; WRCOUNT unchanged; PRDATA=0 on a read of 0x400.
- Change PADDR from 0x10 to 0x14 mid-access with WAITS=2 -> PROTERR=1 and stays 1 until PRESET.
- Drop PSEL mid-wait (WAITS=5) on a write of 0xAAAA5555 to 0x08 -> PROTERR=1; mem[2] unchanged; FSM back in IDLE; the next normal transfer completes correctly.
- Assert PRESET during ACCESS -> next cycle all outputs 0 and counters 0; memory keeps earlier data; a subsequent read of 0x10 returns 0xDEADBEEF.
